cfseq: RTL and testbench
========================

# cfseq

Parametrised successor to the 1052/2150 console function decoder. Accepts prioritised requests (carrier-return latch, shift change, data character), classifies the EBCDIC character, and drives timed one-hot magnet pulses with programmable on/recovery times. Tracks the print case internally and acknowledges each request with a handshake. Sits between the adapter data register/control latches and the printer magnet drivers.

## Interface
- PULSE_CYC, 3: magnet-on cycles for space/lf/bs/tab/lc/uc (>=1)
- CRLF_CYC, 6: magnet-on cycles for carrier return/line feed (>=1)
- RECOV_CYC, 2: magnet-off recovery cycles after any magnet pulse (>=1)
- CNT_W, 8: counter width; must hold max(PULSE_CYC, CRLF_CYC, RECOV_CYC)
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_ready  in  1  printer ready; requests accepted only when 1
- i_cr_req  in  1  carrier-return latch request (level, held until acked)
- i_shift_req  in  1  shift-change request (level)
- i_shift_uc  in  1  target case for shift request (1 = upper)
- i_data_req  in  1  character request (level)
- i_data_reg  in  8  EBCDIC character, bit 7 = b0 (MSB)
- o_ack  out  3  one-cycle ack, one-hot {cr, shift, data}
- o_busy  out  1  operation in progress
- o_done  out  1  one-cycle completion pulse
- o_print  out  1  one-cycle pulse: captured char is printable (non-function)
- o_function  out  1  captured operation is a function (registered, valid while busy)
- o_magnet  out  7  one-hot {space, crlf, lf, bs, tab, lc, uc}
- o_case  out  1  current print case (1 = upper)

## Operation
- States: IDLE, FIRE, RECOV, DONE.
- IDLE: at clock edge with i_ready=1, accept highest-priority asserted request: cr > shift > data. Lower-priority requests untouched, re-evaluated next time IDLE. i_ready=0: nothing accepted.
- Capture i_data_reg on data accept only. Classification: 0x40 space; 0x15 NL -> crlf; 0x25 -> lf; 0x16 -> bs; 0x05 -> tab; other with b0=b1=b4=0, b5=1 -> function, no magnet; everything else printable.
- cr request -> crlf magnet, CRLF_CYC. Shift request with i_shift_uc != o_case -> uc or lc magnet, PULSE_CYC; o_case updated to i_shift_uc on the done cycle. Shift request with i_shift_uc == o_case -> no magnet.
- Magnet ops: FIRE (count down on-time) -> RECOV (RECOV_CYC) -> DONE -> IDLE.
- No-magnet ops (printable, unmapped control, redundant shift): straight to DONE; o_print=1 for printable only.
- o_function = 1 for cr, shift and every function char; 0 for printable.
- i_ready falling mid-operation: pulse and recovery complete unchanged.
- Reset (any time, incl. mid-pulse): state IDLE, all outputs 0, o_case=0 (lower), counter 0. Magnets drop immediately.

## Timing
- Accept at edge ending cycle 0. Cycle 1: o_ack bit=1 (one cycle), o_busy=1.
- Magnet op with on-time N: o_magnet asserted cycles 1..N, low N+1..N+RECOV_CYC, o_done=1 cycle N+RECOV_CYC+1, o_busy high cycles 1..N+RECOV_CYC+1, IDLE cycle N+RECOV_CYC+2 (earliest next accept at end of that cycle).
- No-magnet op: o_ack, o_done (and o_print if printable) all in cycle 1; o_busy cycle 1 only; IDLE cycle 2.
- o_magnet never has more than one bit set; all outputs registered.
- Requester must deassert its request on seeing o_ack; request still high in cycle 1 is ignored (not IDLE).

## Test plan
- Reset, PULSE=3, RECOV=2: data 0x40 -> ack=001 cycle 1, magnet=1000000 cycles 1-3, low 4-5, done cycle 6, o_function=1.
- cr_req and data_req (0xC1) same cycle, CRLF=6 -> cr acked first, crlf magnet cycles 1-6, done cycle 9; 0xC1 then accepted, o_print=1, done same cycle, o_function=0.
- o_case=0, shift_req uc=1 -> uc magnet 3 cycles, o_case=1 at done; repeat uc=1 -> no magnet, ack+done cycle 1.
- Data 0x05/0x16/0x25/0x15 -> tab/bs/lf/crlf bits respectively; 0x07 -> function, no magnet, done cycle 1.
- i_ready=0 with data_req held 10 cycles -> no ack; i_ready=1 -> ack next cycle.
- Assert i_reset=0 during cycle 2 of crlf pulse -> o_magnet, o_busy, o_case = 0 immediately; after release, held request re-accepted.

Source files
------------

// File: rtl/cfseq.sv
// Console function sequencer: prioritised request accept, EBCDIC
// classification and timed one-hot magnet pulses with recovery.
module cfseq #(
  parameter int PULSE_CYC = 3,
  parameter int CRLF_CYC  = 6,
  parameter int RECOV_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ready,
  input  logic       i_cr_req,
  input  logic       i_shift_req,
  input  logic       i_shift_uc,
  input  logic       i_data_req,
  input  logic [7:0] i_data_reg,
  output logic [2:0] o_ack,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_print,
  output logic       o_function,
  output logic [6:0] o_magnet,
  output logic       o_case
);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    RECOV,
    DONE
  } st_t;

  localparam logic [6:0] M_SPACE = 7'b1000000;
  localparam logic [6:0] M_CRLF  = 7'b0100000;
  localparam logic [6:0] M_LF    = 7'b0010000;
  localparam logic [6:0] M_BS    = 7'b0001000;
  localparam logic [6:0] M_TAB   = 7'b0000100;
  localparam logic [6:0] M_LC    = 7'b0000010;
  localparam logic [6:0] M_UC    = 7'b0000001;

  localparam logic [CNT_W-1:0] N_PULSE = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] N_CRLF  = CNT_W'(CRLF_CYC);
  localparam logic [CNT_W-1:0] N_RECOV = CNT_W'(RECOV_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  st_t              st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       mag_q, mag_d;
  logic [2:0]       ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             print_q, print_d;
  logic             func_q, func_d;
  logic             case_q, case_d;
  logic             tgt_q, tgt_d;

  logic [6:0] dmag;
  logic       dfn;

  // Character classifier; b0 is bit 7
  always_comb begin
    dmag = '0;
    case (i_data_reg)
      8'h40:   dmag = M_SPACE;
      8'h15:   dmag = M_CRLF;
      8'h25:   dmag = M_LF;
      8'h16:   dmag = M_BS;
      8'h05:   dmag = M_TAB;
      default: dmag = '0;
    endcase
    dfn = (dmag != '0) ||
          (!i_data_reg[7] && !i_data_reg[6] &&
           !i_data_reg[3] && i_data_reg[2]);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      print_q <= 1'b0;
      func_q  <= 1'b0;
      case_q  <= 1'b0;
      tgt_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      print_q <= print_d;
      func_q  <= func_d;
      case_q  <= case_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    busy_d  = busy_q;
    func_d  = func_q;
    case_d  = case_q;
    tgt_d   = tgt_q;
    ack_d   = '0;
    done_d  = 1'b0;
    print_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (i_ready) begin
          if (i_cr_req) begin
            ack_d  = 3'b100;
            busy_d = 1'b1;
            func_d = 1'b1;
            tgt_d  = case_q;
            mag_d  = M_CRLF;
            cnt_d  = N_CRLF;
            st_d   = FIRE;
          end else if (i_shift_req) begin
            ack_d  = 3'b010;
            busy_d = 1'b1;
            func_d = 1'b1;
            tgt_d  = i_shift_uc;
            if (i_shift_uc != case_q) begin
              mag_d = i_shift_uc ? M_UC : M_LC;
              cnt_d = N_PULSE;
              st_d  = FIRE;
            end else begin
              done_d = 1'b1;
              st_d   = DONE;
            end
          end else if (i_data_req) begin
            ack_d  = 3'b001;
            busy_d = 1'b1;
            func_d = dfn;
            tgt_d  = case_q;
            if (dmag != '0) begin
              mag_d = dmag;
              cnt_d = (dmag == M_CRLF) ? N_CRLF : N_PULSE;
              st_d  = FIRE;
            end else begin
              done_d  = 1'b1;
              print_d = !dfn;
              st_d    = DONE;
            end
          end
        end
      end
      FIRE: begin
        if (cnt_q <= ONE) begin
          mag_d = '0;
          cnt_d = N_RECOV;
          st_d  = RECOV;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RECOV: begin
        if (cnt_q <= ONE) begin
          cnt_d  = '0;
          done_d = 1'b1;
          case_d = tgt_q;
          st_d   = DONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        func_d = 1'b0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign o_ack      = ack_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_print    = print_q;
  assign o_function = func_q;
  assign o_magnet   = mag_q;
  assign o_case     = case_q;

endmodule

// File: tb/tb_cfseq.sv
// Bench for cfseq: timeline scoreboard checked every cycle plus
// hand-computed literal checks for each scenario.
module tb_cfseq;

  localparam int P = 3;
  localparam int C = 6;
  localparam int R = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready = 1'b0;
  logic       cr    = 1'b0;
  logic       sh    = 1'b0;
  logic       uc    = 1'b0;
  logic       dr    = 1'b0;
  logic [7:0] dat   = 8'h00;

  logic [2:0] ack;
  logic       busy, done, prt, fn, cs;
  logic [6:0] mag;

  cfseq #(
    .PULSE_CYC(P),
    .CRLF_CYC (C),
    .RECOV_CYC(R),
    .CNT_W    (8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_ready    (ready),
    .i_cr_req   (cr),
    .i_shift_req(sh),
    .i_shift_uc (uc),
    .i_data_req (dr),
    .i_data_reg (dat),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_done     (done),
    .o_print    (prt),
    .o_function (fn),
    .o_magnet   (mag),
    .o_case     (cs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ack;
    logic       busy;
    logic       done;
    logic       prt;
    logic       fn;
    logic [6:0] mag;
    logic       cs;
  } vec_t;

  vec_t q[$];
  logic mcase  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Expected per-cycle outputs of one whole operation
  task automatic push_op(input logic [2:0] a, input logic [6:0] m,
                         input int n, input logic f, input logic p,
                         input logic nc);
    vec_t v;
    if (m == 7'b0) begin
      v = '{ack: a, busy: 1'b1, done: 1'b1, prt: p, fn: f,
            mag: 7'b0, cs: nc};
      q.push_back(v);
    end else begin
      for (int i = 1; i <= n + R + 1; i++) begin
        v = '0;
        v.busy = 1'b1;
        v.fn   = f;
        v.cs   = mcase;
        if (i == 1) v.ack = a;
        if (i <= n) v.mag = m;
        if (i == n + R + 1) begin
          v.done = 1'b1;
          v.cs   = nc;
        end
        q.push_back(v);
      end
    end
    mcase = nc;
  endtask

  task automatic classify(input logic [7:0] c, output logic [6:0] m,
                          output logic f);
    case (c)
      8'h40:   m = 7'b1000000;
      8'h15:   m = 7'b0100000;
      8'h25:   m = 7'b0010000;
      8'h16:   m = 7'b0001000;
      8'h05:   m = 7'b0000100;
      default: m = 7'b0;
    endcase
    f = (m != 7'b0) || (c[7:6] == 2'b00 && c[3:2] == 2'b01);
  endtask

  initial begin
    forever begin
      logic [6:0] m;
      logic       f;
      logic       idle;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        mcase = 1'b0;
      end else begin
        idle = (q.size() == 0);
        if (!idle) void'(q.pop_front());
        if (idle && ready) begin
          if (cr) begin
            push_op(3'b100, 7'b0100000, C, 1'b1, 1'b0, mcase);
          end else if (sh) begin
            if (uc != mcase)
              push_op(3'b010, uc ? 7'b0000001 : 7'b0000010, P,
                      1'b1, 1'b0, uc);
            else
              push_op(3'b010, 7'b0, P, 1'b1, 1'b0, uc);
          end else if (dr) begin
            classify(dat, m, f);
            push_op(3'b001, m, (m == 7'b0100000) ? C : P, f, !f,
                    mcase);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      vec_t e;
      vec_t a;
      @(negedge clk);
      if (q.size() != 0) begin
        e = q[0];
      end else begin
        e = '0;
        e.cs = mcase;
      end
      a = '{ack: ack, busy: busy, done: done, prt: prt, fn: fn,
            mag: mag, cs: cs};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got %b want %b", $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack == 3'b0 && n < 64);
    checks++;
    if (ack == 3'b0) begin
      errors++;
      $display("FAIL %s ack timeout got %b want nonzero", nm, ack);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (busy && n < 64);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s idle timeout got busy=%b want 0", nm, busy);
    end
  endtask

  logic [7:0] chars [5] = '{8'h05, 8'h16, 8'h25, 8'h15, 8'h07};
  logic [6:0] mags  [5] = '{7'b0000100, 7'b0001000, 7'b0010000,
                            7'b0100000, 7'b0000000};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_mag", 8'(mag), 8'h00);
    chk("rst_case", 8'(cs), 8'h00);
    rst_n = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;

    // space: magnet 1..3, low 4..5, done 6
    dat = 8'h40;
    dr  = 1'b1;
    wait_ack("t1");
    dr = 1'b0;
    chk("t1_ack", 8'(ack), 8'h01);
    chk("t1_mag", 8'(mag), 8'h40);
    chk("t1_fn", 8'(fn), 8'h01);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_mag_c4", 8'(mag), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_done_c6", 8'(done), 8'h01);
    wait_idle("t1");

    // cr beats data; then printable 0xC1
    cr  = 1'b1;
    dr  = 1'b1;
    dat = 8'hC1;
    wait_ack("t2cr");
    cr = 1'b0;
    chk("t2_ack", 8'(ack), 8'h04);
    chk("t2_mag", 8'(mag), 8'h20);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_done_c9", 8'(done), 8'h01);
    wait_ack("t2d");
    dr = 1'b0;
    chk("t2d_ack", 8'(ack), 8'h01);
    chk("t2d_print", 8'(prt), 8'h01);
    chk("t2d_done", 8'(done), 8'h01);
    chk("t2d_fn", 8'(fn), 8'h00);
    wait_idle("t2");

    // shift to upper, then redundant shift
    sh = 1'b1;
    uc = 1'b1;
    wait_ack("t3a");
    sh = 1'b0;
    chk("t3_ack", 8'(ack), 8'h02);
    chk("t3_mag", 8'(mag), 8'h01);
    chk("t3_case0", 8'(cs), 8'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_done", 8'(done), 8'h01);
    chk("t3_case1", 8'(cs), 8'h01);
    wait_idle("t3a");
    sh = 1'b1;
    wait_ack("t3b");
    sh = 1'b0;
    chk("t3b_done", 8'(done), 8'h01);
    chk("t3b_mag", 8'(mag), 8'h00);
    wait_idle("t3b");

    // control characters
    for (int i = 0; i < 5; i++) begin
      dat = chars[i];
      dr  = 1'b1;
      wait_ack("t4");
      dr = 1'b0;
      chk("t4_mag", 8'(mag), 8'(mags[i]));
      chk("t4_fn", 8'(fn), 8'h01);
      if (i == 4) chk("t4_done", 8'(done), 8'h01);
      wait_idle("t4");
    end

    // not ready: no accept
    ready = 1'b0;
    dat   = 8'hC2;
    dr    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t5_noack", 8'(ack), 8'h00);
    end
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_ack", 8'(ack), 8'h01);
    dr = 1'b0;
    wait_idle("t5");

    // reset during crlf pulse, request held through it
    cr = 1'b1;
    wait_ack("t6");
    @(posedge clk);
    #1;
    chk("t6_mag_c2", 8'(mag), 8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mag", 8'(mag), 8'h00);
    chk("t6_rst_busy", 8'(busy), 8'h00);
    chk("t6_rst_case", 8'(cs), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ack("t6b");
    cr = 1'b0;
    chk("t6b_ack", 8'(ack), 8'h04);
    wait_idle("t6b");
    chk("t6b_case", 8'(cs), 8'h00);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
